// File: rtl/fetch_if.sv
// Fetch unit bus bundle: instruction-memory port, instruction queue head and redirect.
// master = fetch unit, slave = memory/controller side.
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [2:0]  imem_funct3;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  modport master (
    output imem_req, imem_addr, imem_funct3, instr_valid, instr_data, instr_pc, halted,
    input  imem_rdata, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, imem_funct3, instr_valid, instr_data, instr_pc, halted,
    output imem_rdata, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: word fetcher feeding a DEPTH-entry prefetch queue with redirect.
// Optional stop-word halting is compiled in with FETCH_STOP_WORD_EN.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic   clk,
  input  logic   rst,
  fetch_if.master bus
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [0:0]    RUN     = 1'b0;
  localparam logic [0:0]    HALT    = 1'b1;

  logic [0:0]    state;
  logic [31:0]   fetch_pc;
  logic          vld_p1;
  logic [31:0]   req_pc_p1;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   last_data;
  logic [31:0]   last_pc;
  logic [AW:0]   occ;
  logic          req;
  logic          stop_hit;
  logic          push;
  logic          pop;
  logic          not_empty;

  // Outstanding response counts against capacity; a same-cycle pop gives no credit.
  assign occ       = count + {{AW{1'b0}}, vld_p1};
  assign req       = !rst && (state == RUN) && !bus.redirect_valid && (occ < DEPTH_C);
  assign not_empty = (count != '0);

`ifdef FETCH_STOP_WORD_EN
  assign stop_hit   = vld_p1 && (state == RUN) && !bus.redirect_valid && (bus.imem_rdata == 32'h0);
  assign bus.halted = (state == HALT);
`else
  assign stop_hit   = 1'b0;
  assign bus.halted = 1'b0;
`endif

  assign push = vld_p1 && (state == RUN) && !stop_hit && !bus.redirect_valid;
  assign pop  = not_empty && bus.instr_ready && !bus.redirect_valid;

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetch_pc;
  assign bus.imem_funct3 = 3'b010;
  assign bus.instr_valid = not_empty;
  assign bus.instr_data  = not_empty ? data_q[rd_ptr] : last_data;
  assign bus.instr_pc    = not_empty ? pc_q[rd_ptr]   : last_pc;

  // Stage p0 -> p1: request issue, queue control
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      fetch_pc  <= RESET_PC;
      vld_p1    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_data <= 32'h0;
      last_pc   <= 32'h0;
    end else begin
      vld_p1 <= req;
      if (pop) begin
        last_data <= data_q[rd_ptr];
        last_pc   <= pc_q[rd_ptr];
      end
      if (bus.redirect_valid) begin
        state    <= RUN;
        fetch_pc <= bus.redirect_pc & 32'hFFFF_FFFC;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (req)      fetch_pc <= fetch_pc + 32'd4;
        if (stop_hit) state    <= HALT;
        if (push)     wr_ptr   <= wr_ptr + 1'b1;
        if (pop)      rd_ptr   <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Stage p1 -> queue: request address and response payload
  always_ff @(posedge clk) begin
    if (req) req_pc_p1 <= fetch_pc;
    if (push) begin
      data_q[wr_ptr] <= bus.imem_rdata;
      pc_q[wr_ptr]   <= req_pc_p1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit: stream, backpressure, redirect, wrap, halt, reset.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   zero_mode;
  int   total = 0;
  int   passed = 0;

`ifdef FETCH_STOP_WORD_EN
  localparam bit ZDEF = 1'b0;
`else
  localparam bit ZDEF = 1'b1;
`endif

  fetch_if bus ();

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a, input bit zm);
    if (a == 32'h0)         return 32'h0050_0093;
    if (a == 32'h4)         return 32'h0010_8113;
    if (a == 32'h10 && zm)  return 32'h0;
    return 32'h1300_0000 | a;
  endfunction

  // Memory answers exactly one cycle after a request, garbage otherwise.
  always @(posedge clk)
    bus.imem_rdata <= bus.imem_req ? word(bus.imem_addr, zero_mode) : 32'hDEAD_BEEF;

  typedef struct {
    bit          do_rst;
    bit          ready;
    bit          redir;
    logic [31:0] rpc;
    bit          zero;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
    bit          e_halt;
  } vec_t;

  vec_t rows[$];

  task automatic add(input bit do_rst, input bit ready, input bit redir, input logic [31:0] rpc,
                     input bit zero, input bit e_req, input logic [31:0] e_addr,
                     input bit e_valid, input logic [31:0] e_pc, input bit e_halt);
    vec_t v;
    v.do_rst = do_rst; v.ready = ready; v.redir = redir; v.rpc = rpc; v.zero = zero;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_halt = e_halt;
    rows.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",  32'(bus.instr_valid), 32'h0);
    chk("rst_data",   bus.instr_data,       32'h0);
    chk("rst_pc",     bus.instr_pc,         32'h0);
    chk("rst_halted", 32'(bus.halted),      32'h0);
    chk("rst_req",    32'(bus.imem_req),    32'h0);
    chk("rst_funct3", 32'(bus.imem_funct3), 32'h2);
    rst = 1'b0;
  endtask

  initial begin
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    zero_mode          = ZDEF;

    // Stream at full rate, then redirect to an unaligned address that wraps.
    add(1,1,0,0,0, 1,32'h0,        0,32'h0,        0);
    add(0,1,0,0,0, 1,32'h4,        0,32'h0,        0);
    add(0,1,0,0,0, 1,32'h8,        1,32'h0,        0);
    add(0,1,0,0,0, 1,32'hC,        1,32'h4,        0);
    add(0,1,0,0,0, 1,32'h10,       1,32'h8,        0);
    add(0,1,1,32'hFFFF_FFFF,0, 0,32'h0, 1,32'hC,   0);
    add(0,1,0,0,0, 1,32'hFFFF_FFFC,0,32'h0,        0);
    add(0,1,0,0,0, 1,32'h0,        0,32'h0,        0);
    add(0,1,0,0,0, 1,32'h4,        1,32'hFFFF_FFFC,0);
    add(0,1,0,0,0, 1,32'h8,        1,32'h0,        0);

    // Backpressure: four entries fill, requests stop, order kept after release.
    add(1,0,0,0,0, 1,32'h0,  0,32'h0, 0);
    add(0,0,0,0,0, 1,32'h4,  0,32'h0, 0);
    add(0,0,0,0,0, 1,32'h8,  1,32'h0, 0);
    add(0,0,0,0,0, 1,32'hC,  1,32'h0, 0);
    for (int k = 0; k < 6; k++) add(0,0,0,0,0, 0,32'h0, 1,32'h0, 0);
    add(0,1,0,0,0, 0,32'h0,  1,32'h0, 0);
    add(0,1,0,0,0, 1,32'h10, 1,32'h4, 0);
    add(0,1,0,0,0, 1,32'h14, 1,32'h8, 0);
    add(0,1,0,0,0, 1,32'h18, 1,32'hC, 0);
    add(0,1,0,0,0, 1,32'h1C, 1,32'h10,0);

    // Redirect with three queued entries and a response in flight.
    add(1,0,0,0,0, 1,32'h0,  0,32'h0, 0);
    add(0,0,0,0,0, 1,32'h4,  0,32'h0, 0);
    add(0,0,0,0,0, 1,32'h8,  1,32'h0, 0);
    add(0,0,0,0,0, 1,32'hC,  1,32'h0, 0);
    add(0,0,1,32'h43,0, 0,32'h0, 1,32'h0, 0);
    add(0,1,0,0,0, 1,32'h40, 0,32'h0, 0);
    add(0,1,0,0,0, 1,32'h44, 0,32'h0, 0);
    add(0,1,0,0,0, 1,32'h48, 1,32'h40,0);
    add(0,1,0,0,0, 1,32'h4C, 1,32'h44,0);

`ifdef FETCH_STOP_WORD_EN
    // Stop word at 0x10 halts fetch; redirect to 0x0 resumes.
    add(1,1,0,0,1, 1,32'h0,  0,32'h0, 0);
    add(0,1,0,0,1, 1,32'h4,  0,32'h0, 0);
    add(0,1,0,0,1, 1,32'h8,  1,32'h0, 0);
    add(0,1,0,0,1, 1,32'hC,  1,32'h4, 0);
    add(0,1,0,0,1, 1,32'h10, 1,32'h8, 0);
    add(0,1,0,0,1, 1,32'h14, 1,32'hC, 0);
    add(0,1,0,0,1, 0,32'h0,  0,32'h0, 1);
    add(0,1,0,0,1, 0,32'h0,  0,32'h0, 1);
    add(0,1,1,32'h0,1, 0,32'h0, 0,32'h0, 1);
    add(0,1,0,0,1, 1,32'h0,  0,32'h0, 0);
    add(0,1,0,0,1, 1,32'h4,  0,32'h0, 0);
    add(0,1,0,0,1, 1,32'h8,  1,32'h0, 0);
`endif

    foreach (rows[i]) begin
      if (rows[i].do_rst) do_reset();
      bus.instr_ready    = rows[i].ready;
      bus.redirect_valid = rows[i].redir;
      bus.redirect_pc    = rows[i].rpc;
      zero_mode          = rows[i].zero | ZDEF;
      #1;
      chk($sformatf("row%0d_halted", i), 32'(bus.halted),      32'(rows[i].e_halt));
      chk($sformatf("row%0d_req", i),    32'(bus.imem_req),    32'(rows[i].e_req));
      chk($sformatf("row%0d_valid", i),  32'(bus.instr_valid), 32'(rows[i].e_valid));
      if (rows[i].e_req)
        chk($sformatf("row%0d_addr", i), bus.imem_addr, rows[i].e_addr);
      if (rows[i].e_valid) begin
        chk($sformatf("row%0d_pc", i),   bus.instr_pc,   rows[i].e_pc);
        chk($sformatf("row%0d_data", i), bus.instr_data, word(rows[i].e_pc, zero_mode));
      end
      @(posedge clk);
      #1;
    end

    // Reset and redirect together while the queue is full.
    bus.redirect_valid = 1'b0;
    zero_mode = ZDEF;
    do_reset();
    repeat (6) @(posedge clk);
    #1;
    chk("full_valid", 32'(bus.instr_valid), 32'h1);
    chk("full_req",   32'(bus.imem_req),    32'h0);
    rst = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h80;
    @(posedge clk);
    #1;
    chk("mid_rst_valid",  32'(bus.instr_valid), 32'h0);
    chk("mid_rst_data",   bus.instr_data,       32'h0);
    chk("mid_rst_pc",     bus.instr_pc,         32'h0);
    chk("mid_rst_halted", 32'(bus.halted),      32'h0);
    chk("mid_rst_req",    32'(bus.imem_req),    32'h0);
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    #1;
    chk("post_rst_req",  32'(bus.imem_req), 32'h1);
    chk("post_rst_addr", bus.imem_addr,     32'h0);
    bus.instr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(bus.instr_valid), 32'h1);
    chk("post_rst_pc",    bus.instr_pc,         32'h0);
    chk("post_rst_word",  bus.instr_data,       32'h0050_0093);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
